// File: rtl/cpu_types_pkg.sv
// Shared types for the data-side request controller: word type, wait-counter
// width and the request FSM state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } req_state_t;

endpackage

// File: rtl/link_reg.sv
// Load-linked reservation register with the address compares used by SC and by
// ordinary stores that hit the reserved address.
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = $bits(word_t),
  parameter bit EN     = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clear,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              valid,
  output logic              sc_ok,
  output logic              wr_match
);

  generate
    if (EN) begin : g_link
      logic [ADDR_W-1:0] addr;
      logic              inval_hit;

      assign inval_hit = inval && (inval_addr == addr);

      // A snoop hit in the same cycle as the SC makes the SC fail.
      assign sc_ok    = valid && (sc_addr == addr) && !inval_hit;
      assign wr_match = valid && (wr_addr == addr);

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          valid <= 1'b0;
          addr  <= '0;
        end else if (set) begin
          valid <= 1'b1;
          addr  <= set_addr;
        end else if (clear || inval_hit) begin
          valid <= 1'b0;
        end
      end
    end else begin : g_nolink
      logic unused_in;
      assign unused_in = ^{CLK, nRST, set, set_addr, clear, inval, inval_addr, sc_addr, wr_addr};
      assign valid    = 1'b0;
      assign sc_ok    = 1'b0;
      assign wr_match = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/data_request_ctrl.sv
// Data-memory request sequencer: turns fetched loads/stores into REN/WEN
// requests, times out on a missing dhit, and handles LL/SC reservations.
//
// state | meaning
// IDLE  | no request outstanding, accepts the next ihit
// READ  | dmemREN held until dhit or timeout
// WRITE | dmemWEN held until dhit or timeout (may be an SC)
// ERR   | timed out, busy with timeout_err until flush
module data_request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = $bits(word_t),
  parameter int DATA_W  = $bits(word_t),
  parameter int TIMEOUT = 255,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              link,
  input  logic              cond,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              flush,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              busy,
  output logic              timeout_err,
  output logic              sc_done,
  output logic              sc_result,
  output logic              link_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  req_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             is_sc;

  logic start, rd_acc, wr_req, sc_req, sc_fail, wr_acc, wr_done;
  logic link_set, link_clr, sc_ok, wr_match;

  always_comb begin
    start    = (state == IDLE) && ihit && !flush;
    rd_acc   = start && mem_read;
    // A combined read+write is taken as a read.
    wr_req   = start && mem_write && !mem_read;
    sc_req   = wr_req && cond && LLSC_EN;
    sc_fail  = sc_req && !sc_ok;
    wr_acc   = wr_req && !sc_fail;
    wr_done  = (state == WRITE) && dhit && !flush;
    link_set = rd_acc && link && LLSC_EN;
    link_clr = sc_fail || (wr_done && (is_sc || wr_match));
  end

  link_reg #(
    .ADDR_W (ADDR_W),
    .EN     (LLSC_EN)
  ) u_link_reg (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (link_set),
    .set_addr   (addr_in),
    .clear      (link_clr),
    .inval      (inval),
    .inval_addr (inval_addr),
    .sc_addr    (addr_in),
    .wr_addr    (dmemaddr),
    .valid      (link_valid),
    .sc_ok      (sc_ok),
    .wr_match   (wr_match)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      is_sc       <= 1'b0;
      dmemREN     <= 1'b0;
      dmemWEN     <= 1'b0;
      dmemaddr    <= '0;
      dmemstore   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      sc_done     <= 1'b0;
      sc_result   <= 1'b0;
    end else begin
      sc_done <= 1'b0;
      if (flush) begin
        // Abort drops any pending SC silently; sc_result keeps its old value.
        state       <= IDLE;
        cnt         <= '0;
        is_sc       <= 1'b0;
        dmemREN     <= 1'b0;
        dmemWEN     <= 1'b0;
        busy        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rd_acc) begin
              state    <= READ;
              cnt      <= '0;
              dmemaddr <= addr_in;
              dmemREN  <= 1'b1;
              busy     <= 1'b1;
            end else if (wr_acc) begin
              state     <= WRITE;
              cnt       <= '0;
              is_sc     <= sc_req;
              dmemaddr  <= addr_in;
              dmemstore <= wdata_in;
              dmemWEN   <= 1'b1;
              busy      <= 1'b1;
            end else if (sc_fail) begin
              sc_done   <= 1'b1;
              sc_result <= 1'b0;
            end
          end
          READ, WRITE: begin
            if (dhit) begin
              state   <= IDLE;
              cnt     <= '0;
              is_sc   <= 1'b0;
              dmemREN <= 1'b0;
              dmemWEN <= 1'b0;
              busy    <= 1'b0;
              if (wr_done && is_sc) begin
                sc_done   <= 1'b1;
                sc_result <= 1'b1;
              end
            end else if (cnt == CNT_LAST) begin
              state       <= ERR;
              dmemREN     <= 1'b0;
              dmemWEN     <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ERR: begin
            timeout_err <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_request_ctrl.sv
// Directed bench for data_request_ctrl: a transaction-level model is checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_data_request_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ihit, dhit, mem_read, mem_write, link, cond, flush, inval;
  logic [31:0] addr_in, wdata_in, inval_addr;
  logic        dmemREN, dmemWEN, busy, timeout_err, sc_done, sc_result, link_valid;
  logic [31:0] dmemaddr, dmemstore;

  int n_vec = 0;
  int n_bad = 0;

  // Model: kind 0 = nothing outstanding, 1 = load, 2 = store, 3 = timed out.
  int          m_kind = 0;
  int          m_wait = 0;
  bit          m_sc = 1'b0;
  bit          m_lv = 1'b0;
  bit          m_done = 1'b0;
  bit          m_res = 1'b0;
  logic [31:0] m_la = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  data_request_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO),
    .LLSC_EN (1'b1)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .link        (link),
    .cond        (cond),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .flush       (flush),
    .inval       (inval),
    .inval_addr  (inval_addr),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .busy        (busy),
    .timeout_err (timeout_err),
    .sc_done     (sc_done),
    .sc_result   (sc_result),
    .link_valid  (link_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          inv_hit, ok, nlv;
    logic [31:0] nla;
    inv_hit = inval && (inval_addr == m_la);
    nlv     = m_lv && !inv_hit;
    nla     = m_la;
    m_done  = 1'b0;
    if (flush) begin
      m_kind = 0;
      m_wait = 0;
      m_sc   = 1'b0;
    end else if (m_kind == 0) begin
      if (ihit && mem_read) begin
        m_kind = 1; m_wait = 0; m_addr = addr_in;
        if (link) begin nlv = 1'b1; nla = addr_in; end
      end else if (ihit && mem_write) begin
        ok = !cond || (m_lv && m_la == addr_in && !inv_hit);
        if (ok) begin
          m_kind = 2; m_wait = 0; m_addr = addr_in; m_data = wdata_in; m_sc = cond;
        end else begin
          m_done = 1'b1; m_res = 1'b0; nlv = 1'b0;
        end
      end
    end else if (m_kind == 1 || m_kind == 2) begin
      if (dhit) begin
        if (m_kind == 2 && m_sc) begin
          m_done = 1'b1; m_res = 1'b1; nlv = 1'b0;
        end else if (m_kind == 2 && m_addr == m_la) begin
          nlv = 1'b0;
        end
        m_kind = 0; m_wait = 0; m_sc = 1'b0;
      end else if (m_wait == TO - 1) begin
        m_kind = 3;
      end else begin
        m_wait = m_wait + 1;
      end
    end
    m_lv = nlv;
    m_la = nla;
  endtask

  // Compare at the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial forever begin
    @(negedge CLK);
    if (!nRST) begin
      m_kind = 0; m_wait = 0; m_sc = 1'b0; m_lv = 1'b0; m_la = '0;
      m_done = 1'b0; m_res = 1'b0;
    end
    chk1("m_ren", dmemREN, m_kind == 1);
    chk1("m_wen", dmemWEN, m_kind == 2);
    chk1("m_busy", busy, m_kind != 0);
    chk1("m_terr", timeout_err, m_kind == 3);
    chk1("m_sc_done", sc_done, m_done);
    chk1("m_sc_result", sc_result, m_res);
    chk1("m_link_valid", link_valid, m_lv);
    if (m_kind == 1 || m_kind == 2) chk32("m_addr", dmemaddr, m_addr);
    if (m_kind == 2) chk32("m_store", dmemstore, m_data);
    if (nRST) model_step();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    ihit = 0; dhit = 0; mem_read = 0; mem_write = 0; link = 0; cond = 0;
    flush = 0; inval = 0;
  endtask

  task automatic req(input bit rd, input bit wr, input bit lk, input bit cd,
                     input logic [31:0] a, input logic [31:0] d);
    ihit = 1; mem_read = rd; mem_write = wr; link = lk; cond = cd;
    addr_in = a; wdata_in = d;
  endtask

  task automatic ll_done(input logic [31:0] a);
    req(1, 0, 1, 0, a, 32'h0); tick(); idle_in();
    dhit = 1; tick(); idle_in();
  endtask

  initial begin
    idle_in();
    addr_in = '0; wdata_in = '0; inval_addr = '0;
    #1 nRST = 0;
    #2;
    chk1("rst_ren", dmemREN, 0);
    chk1("rst_busy", busy, 0);
    chk1("rst_link", link_valid, 0);
    tick(); tick(); nRST = 1;
    tick();

    // load 0x100, dhit in the third REN cycle; write attempt while busy
    req(1, 0, 0, 0, 32'h100, 32'h0); tick(); idle_in();
    chk1("rd_ren_c2", dmemREN, 1);
    chk32("rd_addr", dmemaddr, 32'h100);
    req(0, 1, 0, 0, 32'h999, 32'h1); tick(); idle_in();
    chk1("rd_ren_c3", dmemREN, 1);
    tick();
    chk1("rd_ren_c4", dmemREN, 1);
    chk32("busy_no_latch", dmemaddr, 32'h100);
    dhit = 1; tick(); idle_in();
    chk1("rd_ren_c5", dmemREN, 0);
    chk1("rd_busy_c5", busy, 0);

    // store with no dhit: 4 WEN cycles then error until flush
    req(0, 1, 0, 0, 32'h200, 32'hDEADBEEF); tick(); idle_in();
    chk32("to_store", dmemstore, 32'hDEADBEEF);
    tick(); tick(); tick();
    chk1("to_wen_c4", dmemWEN, 1);
    tick();
    chk1("to_wen_off", dmemWEN, 0);
    chk1("to_err", timeout_err, 1);
    chk1("to_busy", busy, 1);
    dhit = 1; ihit = 1; mem_read = 1; tick(); idle_in(); tick();
    chk1("to_err_hold", timeout_err, 1);
    flush = 1; tick(); idle_in();
    chk1("to_flush_err", timeout_err, 0);
    chk1("to_flush_busy", busy, 0);

    // dhit on the last allowed wait cycle still completes
    req(0, 1, 0, 0, 32'h210, 32'h5); tick(); idle_in();
    tick(); tick(); tick();
    dhit = 1; tick(); idle_in();
    chk1("edge_err", timeout_err, 0);
    chk1("edge_busy", busy, 0);

    // read+write together is a read; flush beats ihit in IDLE
    req(1, 1, 0, 0, 32'h120, 32'h9); tick(); idle_in();
    chk1("rw_ren", dmemREN, 1);
    chk1("rw_wen", dmemWEN, 0);
    dhit = 1; tick(); idle_in();
    req(1, 0, 0, 0, 32'h130, 32'h0); flush = 1; tick(); idle_in();
    chk1("flush_ihit", busy, 0);

    // LL then successful SC
    ll_done(32'h300);
    chk1("ll_valid", link_valid, 1);
    req(0, 1, 0, 1, 32'h300, 32'h55); tick(); idle_in();
    chk1("sc_wen", dmemWEN, 1);
    dhit = 1; tick(); idle_in();
    chk1("sc_done", sc_done, 1);
    chk1("sc_ok", sc_result, 1);
    chk1("sc_link_clr", link_valid, 0);
    tick();
    chk1("sc_pulse", sc_done, 0);
    chk1("sc_hold", sc_result, 1);

    // invalidate then SC fails without a write
    ll_done(32'h300);
    inval = 1; inval_addr = 32'h300; tick(); idle_in();
    chk1("inval_clr", link_valid, 0);
    req(0, 1, 0, 1, 32'h300, 32'h66); tick(); idle_in();
    chk1("scf_wen", dmemWEN, 0);
    chk1("scf_done", sc_done, 1);
    chk1("scf_res", sc_result, 0);

    // same-cycle snoop makes SC fail; non-matching snoop leaves link
    ll_done(32'h300);
    req(0, 1, 0, 1, 32'h300, 32'h67); inval = 1; inval_addr = 32'h300; tick(); idle_in();
    chk1("scs_done", sc_done, 1);
    chk1("scs_wen", dmemWEN, 0);
    ll_done(32'h340);
    inval = 1; inval_addr = 32'h344; tick(); idle_in();
    chk1("inval_miss", link_valid, 1);
    req(0, 1, 0, 1, 32'h348, 32'h68); tick(); idle_in();
    chk1("sc_mis_res", sc_result, 0);
    chk1("sc_mis_lv", link_valid, 0);

    // plain stores: other address keeps link, same address clears it
    ll_done(32'h400);
    req(0, 1, 0, 0, 32'h404, 32'h1); tick(); idle_in();
    dhit = 1; tick(); idle_in();
    chk1("st_other", link_valid, 1);
    req(0, 1, 0, 0, 32'h400, 32'h2); tick(); idle_in();
    dhit = 1; tick(); idle_in();
    chk1("st_same", link_valid, 0);

    // flush with dhit in READ; flush of a pending SC
    req(1, 0, 0, 0, 32'h500, 32'h0); tick(); idle_in();
    flush = 1; dhit = 1; tick(); idle_in();
    chk1("fd_ren", dmemREN, 0);
    chk1("fd_done", sc_done, 0);
    ll_done(32'h600);
    req(0, 1, 0, 1, 32'h600, 32'h77); tick(); idle_in();
    flush = 1; dhit = 1; tick(); idle_in();
    chk1("fsc_done", sc_done, 0);
    chk1("fsc_link", link_valid, 1);
    req(0, 1, 0, 1, 32'h600, 32'h78); tick(); idle_in();
    dhit = 1; tick(); idle_in();
    chk1("sc2_res", sc_result, 1);

    // async reset in the middle of a store
    ll_done(32'h700);
    req(0, 1, 0, 0, 32'h704, 32'h79); tick(); idle_in();
    chk1("pre_rst_wen", dmemWEN, 1);
    #1 nRST = 0;
    #1;
    chk1("arst_wen", dmemWEN, 0);
    chk1("arst_busy", busy, 0);
    chk1("arst_res", sc_result, 0);
    chk1("arst_link", link_valid, 0);
    tick(); nRST = 1;
    tick();
    req(0, 1, 0, 1, 32'h700, 32'h7A); tick(); idle_in();
    chk1("post_rst_sc", sc_done, 1);
    chk1("post_rst_wen", dmemWEN, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
